fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the free-running PC and fetch logic inside the core. It owns the PC register and issues requests to a synchronous instruction memory with fixed 1-cycle latency. Returned instructions are buffered in a small fetch queue and presented to decode over a valid/ready handshake. It also supports redirect (branch/jump), backpressure and configurable widths and queue depth.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a 1-cycle-latency
// instruction memory and buffers the returned instructions for decode.
module fetch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_inst,
    output logic [PC_W-1:0]   fetch_pc,
    input  logic              dec_ready
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] fq_inst_q [FQ_DEPTH];
    logic [PC_W-1:0]   fq_pc_q   [FQ_DEPTH];

    logic             pop;
    logic             push;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] lim;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake and credit check: a request is only issued if its response is
    // guaranteed a free queue slot, so a full queue never sees a push.
    always_comb begin
        fetch_valid    = rst_n & (count_q != '0) & ~redirect_valid;
        pop            = fetch_valid & dec_ready;
        occ            = OCC_W'(count_q) + OCC_W'(inflight_q);
        lim            = OCC_W'(FQ_DEPTH) + OCC_W'(pop);
        imem_req_valid = rst_n & ~redirect_valid & (occ < lim);
        imem_req_addr  = pc_q;
        push           = rst_n & imem_resp_valid & inflight_q & ~redirect_valid;
        fetch_inst     = fetch_valid ? fq_inst_q[head_q] : '0;
        fetch_pc       = fetch_valid ? fq_pc_q[head_q]   : '0;
    end

    // Next-state: redirect flushes the queue and overrides issue, push and pop.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (imem_req_valid) begin
                pc_d          = pc_q + PC_W'(4);
                inflight_pc_d = pc_q;
                inflight_d    = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_inst_q[tail_q] <= imem_resp_data;
            fq_pc_q[tail_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit: three instances cover the
// default configuration, an 8-bit PC wraparound and a 4-deep queue.
module tb_fetch_unit;

    logic clk;
    int   n_checks;
    int   n_pass;

    // Instance A: PC_W=32, RESET_PC=0x100, FQ_DEPTH=2
    logic        a_rst_n, a_req_valid, a_resp_valid, a_redirect, a_fetch_valid, a_dec_ready, a_spur;
    logic [31:0] a_req_addr, a_resp_data, a_redirect_pc, a_fetch_inst, a_fetch_pc;
    // Instance B: PC_W=8, RESET_PC=0xF8, FQ_DEPTH=2
    logic        b_rst_n, b_req_valid, b_resp_valid, b_redirect, b_fetch_valid, b_dec_ready;
    logic [7:0]  b_req_addr, b_redirect_pc, b_fetch_pc;
    logic [31:0] b_resp_data, b_fetch_inst;
    // Instance C: PC_W=32, RESET_PC=0x100, FQ_DEPTH=4
    logic        c_rst_n, c_req_valid, c_resp_valid, c_redirect, c_fetch_valid, c_dec_ready;
    logic [31:0] c_req_addr, c_resp_data, c_redirect_pc, c_fetch_inst, c_fetch_pc;

    fetch_unit #(.PC_W(32), .INST_W(32), .RESET_PC(32'h100), .FQ_DEPTH(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr),
        .imem_resp_valid(a_resp_valid), .imem_resp_data(a_resp_data), .redirect_valid(a_redirect),
        .redirect_pc(a_redirect_pc), .fetch_valid(a_fetch_valid), .fetch_inst(a_fetch_inst),
        .fetch_pc(a_fetch_pc), .dec_ready(a_dec_ready));

    fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(8'hF8), .FQ_DEPTH(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
        .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data), .redirect_valid(b_redirect),
        .redirect_pc(b_redirect_pc), .fetch_valid(b_fetch_valid), .fetch_inst(b_fetch_inst),
        .fetch_pc(b_fetch_pc), .dec_ready(b_dec_ready));

    fetch_unit #(.PC_W(32), .INST_W(32), .RESET_PC(32'h100), .FQ_DEPTH(4)) u_c (
        .clk(clk), .rst_n(c_rst_n), .imem_req_valid(c_req_valid), .imem_req_addr(c_req_addr),
        .imem_resp_valid(c_resp_valid), .imem_resp_data(c_resp_data), .redirect_valid(c_redirect),
        .redirect_pc(c_redirect_pc), .fetch_valid(c_fetch_valid), .fetch_inst(c_fetch_inst),
        .fetch_pc(c_fetch_pc), .dec_ready(c_dec_ready));

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always #5 clk = ~clk;

    // 1-cycle instruction memories; a_spur injects a response with no request
    always @(posedge clk) begin
        a_resp_valid <= a_req_valid | a_spur;
        a_resp_data  <= inst_of(a_req_addr);
        b_resp_valid <= b_req_valid;
        b_resp_data  <= inst_of({24'h0, b_req_addr});
        c_resp_valid <= c_req_valid;
        c_resp_data  <= inst_of(c_req_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        step();
        #1;
        n_checks++; if (a_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", a_req_valid); else n_pass++;
        n_checks++; if (a_fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid got=%b exp=0", a_fetch_valid); else n_pass++;
        n_checks++; if (a_fetch_inst !== 32'h0) $display("FAIL reset_fetch_inst got=%h exp=0", a_fetch_inst); else n_pass++;
        n_checks++; if (a_fetch_pc !== 32'h0) $display("FAIL reset_fetch_pc got=%h exp=0", a_fetch_pc); else n_pass++;
        n_checks++; if (a_req_addr !== 32'h100) $display("FAIL reset_req_addr got=%h exp=100", a_req_addr); else n_pass++;
    endtask

    task automatic test_run();
        logic [31:0] e;
        step();
        a_rst_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) step();
            if (k != 0) #1;
            e = 32'h100 + 32'(4 * k);
            n_checks++; if (a_req_valid !== 1'b1 || a_req_addr !== e)
                $display("FAIL run_req k=%0d got=%b/%h exp=1/%h", k, a_req_valid, a_req_addr, e); else n_pass++;
            if (k < 2) begin
                n_checks++; if (a_fetch_valid !== 1'b0) $display("FAIL run_early_valid k=%0d got=%b exp=0", k, a_fetch_valid); else n_pass++;
            end else begin
                e = 32'h100 + 32'(4 * (k - 2));
                n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== e || a_fetch_inst !== inst_of(e))
                    $display("FAIL run_fetch k=%0d got=%b/%h/%h exp=1/%h/%h", k, a_fetch_valid, a_fetch_pc, a_fetch_inst, e, inst_of(e)); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        for (int c = 8; c < 14; c++) begin
            step();
            a_dec_ready = 1'b0;
            #1;
            n_checks++; if (a_req_valid !== 1'b0) $display("FAIL bp_req_valid c=%0d got=%b exp=0", c, a_req_valid); else n_pass++;
            n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h118 || a_fetch_inst !== inst_of(32'h118))
                $display("FAIL bp_head c=%0d got=%b/%h/%h exp=1/118/%h", c, a_fetch_valid, a_fetch_pc, a_fetch_inst, inst_of(32'h118)); else n_pass++;
        end
        for (int c = 14; c < 20; c++) begin
            step();
            a_dec_ready = 1'b1;
            #1;
            e = 32'h118 + 32'(4 * (c - 14));
            n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== e || a_fetch_inst !== inst_of(e))
                $display("FAIL bp_drain c=%0d got=%b/%h exp=1/%h", c, a_fetch_valid, a_fetch_pc, e); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        step();
        a_rst_n = 1'b0;
        #1;
        step();
        a_rst_n = 1'b1;
        #1;
        n_checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h100) $display("FAIL rd_c0_req got=%b/%h exp=1/100", a_req_valid, a_req_addr); else n_pass++;
        step();
        #1;
        // one entry queued and a request in flight: every credit is used
        step();
        a_dec_ready   = 1'b0;
        a_redirect    = 1'b1;
        a_redirect_pc = 32'h203;
        #1;
        n_checks++; if (a_req_valid !== 1'b0) $display("FAIL rd_cycle_req got=%b exp=0", a_req_valid); else n_pass++;
        n_checks++; if (a_fetch_valid !== 1'b0 || a_fetch_pc !== 32'h0 || a_fetch_inst !== 32'h0)
            $display("FAIL rd_cycle_fetch got=%b/%h/%h exp=0/0/0", a_fetch_valid, a_fetch_pc, a_fetch_inst); else n_pass++;
        step();
        a_redirect  = 1'b0;
        a_dec_ready = 1'b1;
        #1;
        n_checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h200) $display("FAIL rd_new_req got=%b/%h exp=1/200", a_req_valid, a_req_addr); else n_pass++;
        n_checks++; if (a_fetch_valid !== 1'b0) $display("FAIL rd_flushed got=%b exp=0", a_fetch_valid); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b0) $display("FAIL rd_dropped_resp got=%b/%h exp=0", a_fetch_valid, a_fetch_pc); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h200 || a_fetch_inst !== inst_of(32'h200))
            $display("FAIL rd_first got=%b/%h/%h exp=1/200", a_fetch_valid, a_fetch_pc, a_fetch_inst); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h204) $display("FAIL rd_second got=%b/%h exp=1/204", a_fetch_valid, a_fetch_pc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        a_dec_ready = 1'b0;
        #1;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h208 || a_req_valid !== 1'b0)
            $display("FAIL b2b_full got=%b/%h/%b exp=1/208/0", a_fetch_valid, a_fetch_pc, a_req_valid); else n_pass++;
        step();
        a_redirect    = 1'b1;
        a_redirect_pc = 32'h300;
        #1;
        n_checks++; if (a_req_valid !== 1'b0 || a_fetch_valid !== 1'b0) $display("FAIL b2b_first got=%b/%b exp=0/0", a_req_valid, a_fetch_valid); else n_pass++;
        step();
        a_redirect_pc = 32'h407;
        #1;
        n_checks++; if (a_req_valid !== 1'b0 || a_fetch_valid !== 1'b0) $display("FAIL b2b_second got=%b/%b exp=0/0", a_req_valid, a_fetch_valid); else n_pass++;
        step();
        a_redirect  = 1'b0;
        a_dec_ready = 1'b1;
        #1;
        n_checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h404) $display("FAIL b2b_req got=%b/%h exp=1/404", a_req_valid, a_req_addr); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b0 || a_req_addr !== 32'h408) $display("FAIL b2b_gap got=%b/%h exp=0/408", a_fetch_valid, a_req_addr); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h404) $display("FAIL b2b_fetch got=%b/%h exp=1/404", a_fetch_valid, a_fetch_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step();
        a_rst_n = 1'b0;
        a_spur  = 1'b1;
        #1;
        n_checks++; if (a_req_valid !== 1'b0 || a_fetch_valid !== 1'b0 || a_fetch_pc !== 32'h0 || a_fetch_inst !== 32'h0)
            $display("FAIL mid_reset_outputs got=%b/%b/%h/%h exp=0/0/0/0", a_req_valid, a_fetch_valid, a_fetch_pc, a_fetch_inst); else n_pass++;
        step();
        a_rst_n = 1'b1;
        a_spur  = 1'b0;
        #1;
        n_checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h100 || a_fetch_valid !== 1'b0)
            $display("FAIL mid_restart got=%b/%h/%b exp=1/100/0", a_req_valid, a_req_addr, a_fetch_valid); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b0) $display("FAIL mid_stale got=%b/%h exp=0", a_fetch_valid, a_fetch_pc); else n_pass++;
        step();
        #1;
        n_checks++; if (a_fetch_valid !== 1'b1 || a_fetch_pc !== 32'h100) $display("FAIL mid_first got=%b/%h exp=1/100", a_fetch_valid, a_fetch_pc); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        step();
        b_rst_n = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) step();
            if (k != 0) #1;
            e = 8'hF8 + 8'(4 * k);
            n_checks++; if (b_req_valid !== 1'b1 || b_req_addr !== e) $display("FAIL wrap_req k=%0d got=%b/%h exp=1/%h", k, b_req_valid, b_req_addr, e); else n_pass++;
            if (k >= 2) begin
                e = 8'hF8 + 8'(4 * (k - 2));
                n_checks++; if (b_fetch_valid !== 1'b1 || b_fetch_pc !== e || b_fetch_inst !== inst_of({24'h0, e}))
                    $display("FAIL wrap_fetch k=%0d got=%b/%h exp=1/%h", k, b_fetch_valid, b_fetch_pc, e); else n_pass++;
            end
        end
    endtask

    task automatic test_stress();
        int          occ;
        int          infl;
        logic [31:0] exp_pc;
        logic        redir, fv_e, pop_e, req_e, push_e;
        occ    = 0;
        infl   = 0;
        exp_pc = 32'h100;
        step();
        c_rst_n     = 1'b1;
        c_dec_ready = 1'b1;
        c_redirect  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i != 0) step();
            redir         = ($urandom_range(0, 19) == 0);
            c_redirect    = redir;
            c_redirect_pc = $urandom;
            c_dec_ready   = ($urandom_range(0, 3) != 0);
            #1;
            fv_e   = (occ != 0) && !redir;
            pop_e  = fv_e && c_dec_ready;
            req_e  = !redir && ((occ + infl - int'(pop_e)) < 4);
            push_e = c_resp_valid && (infl != 0) && !redir;
            n_checks++; if (c_req_valid !== req_e) $display("FAIL st_req i=%0d got=%b exp=%b", i, c_req_valid, req_e); else n_pass++;
            n_checks++; if (c_fetch_valid !== fv_e) $display("FAIL st_valid i=%0d got=%b exp=%b", i, c_fetch_valid, fv_e); else n_pass++;
            if (pop_e) begin
                n_checks++; if (c_fetch_pc !== exp_pc || c_fetch_inst !== inst_of(exp_pc))
                    $display("FAIL st_seq i=%0d got=%h/%h exp=%h/%h", i, c_fetch_pc, c_fetch_inst, exp_pc, inst_of(exp_pc)); else n_pass++;
                exp_pc = exp_pc + 32'd4;
            end
            if (push_e) begin
                n_checks++; if (occ >= 4) $display("FAIL st_push_full i=%0d occ=%0d exp<4", i, occ); else n_pass++;
            end
            if (redir) begin
                occ    = 0;
                infl   = 0;
                exp_pc = c_redirect_pc & 32'hFFFF_FFFC;
            end else begin
                occ  = occ + int'(push_e) - int'(pop_e);
                infl = int'(req_e);
            end
        end
        c_redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk      = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        a_rst_n = 1'b0; a_redirect = 1'b0; a_redirect_pc = '0; a_dec_ready = 1'b1; a_spur = 1'b0;
        b_rst_n = 1'b0; b_redirect = 1'b0; b_redirect_pc = '0; b_dec_ready = 1'b1;
        c_rst_n = 1'b0; c_redirect = 1'b0; c_redirect_pc = '0; c_dec_ready = 1'b1;
        test_reset();
        test_run();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_stress();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
